spi_display_receiver: RTL and testbench

//  SPI target (display side) of our SPI display link: oversamples CS/SCK/SDI/DC/RESET

---
 rtl/spi_display_receiver.sv | 131 +++++++++++++
 tb/tb_spi_display_receiver.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_display_receiver.sv
// spi_display_receiver: oversampled SPI display target that rebuilds words and
// queues {data, len-1, dc} entries in a small show-ahead FIFO.
module spi_display_receiver #(
    parameter int WORD_BITS   = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
)(
    input  logic                         CLK_25MHz,
    input  logic                         RESET,
    input  logic                         SPI_CS,
    input  logic                         SPI_RESET,
    input  logic                         SPI_DC,
    input  logic                         SPI_SDI,
    input  logic                         SPI_SCK,
    output logic [WORD_BITS-1:0]         RX_DATA,
    output logic [$clog2(WORD_BITS)-1:0] RX_LEN,
    output logic                         RX_MODE,
    output logic                         RX_VALID,
    input  logic                         RX_ACK,
    output logic                         OVERFLOW,
    output logic                         DISP_IN_RESET
);
    localparam int LW = $clog2(WORD_BITS);
    localparam int CW = $clog2(WORD_BITS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    logic [4:0] sync_q [SYNC_STAGES];
    logic cs_s, rst_s, sck_s, sdi_s, dc_s, sck_prev_q, sck_rise;
    state_t state_q, state_d;
    logic [WORD_BITS-1:0] shreg_q, shreg_d, shifted;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic mode_q, mode_d;
    logic push, push_mode;
    logic [WORD_BITS-1:0] push_data;
    logic [LW-1:0] push_len;
    logic [WORD_BITS+LW:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic empty, full, pop, wr_en, overflow_q;

    // Stage order {CS, RESET, SCK, SDI, DC}; reset loads the idle link levels.
    always_ff @(posedge CLK_25MHz) begin
        if (RESET) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 5'b11000;
            sck_prev_q <= 1'b0;
        end else begin
            sync_q[0] <= {SPI_CS, SPI_RESET, SPI_SCK, SPI_SDI, SPI_DC};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            sck_prev_q <= sck_s;
        end
    end

    assign {cs_s, rst_s, sck_s, sdi_s, dc_s} = sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign shifted  = {shreg_q[WORD_BITS-2:0], sdi_s};
    assign cnt_inc  = cnt_q + 1'b1;

    always_ff @(posedge CLK_25MHz) begin
        if (RESET) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    // Shift register is cleared on every push so a partial word is already right-aligned.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        push      = 1'b0;
        push_data = shifted;
        push_len  = LW'(WORD_BITS - 1);
        push_mode = mode_q;
        if (!rst_s) begin
            state_d = HOLD;
            shreg_d = '0;
            cnt_d   = '0;
        end else if (state_q == HOLD) begin
            state_d = cs_s ? IDLE : SHIFT;
        end else if (state_q == IDLE) begin
            state_d = cs_s ? IDLE : SHIFT;
        end else if (cs_s) begin
            state_d   = IDLE;
            shreg_d   = '0;
            cnt_d     = '0;
            push      = cnt_q != '0;
            push_data = shreg_q;
            push_len  = LW'(cnt_q - 1'b1);
        end else if (sck_rise) begin
            mode_d    = (cnt_q == '0) ? dc_s : mode_q;
            push_mode = mode_d;
            push      = cnt_inc == CW'(WORD_BITS);
            shreg_d   = push ? '0 : shifted;
            cnt_d     = push ? '0 : cnt_inc;
        end
    end

    assign empty    = wr_ptr_q == rd_ptr_q;
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop      = RX_ACK & ~empty;
    assign wr_en    = push & (~full | pop);
    assign RX_VALID = ~empty;
    assign OVERFLOW = overflow_q;
    assign DISP_IN_RESET = ~rst_s;
    assign {RX_MODE, RX_LEN, RX_DATA} = RX_VALID ? mem_q[rd_ptr_q[AW-1:0]] : '0;

    always_ff @(posedge CLK_25MHz) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= {push_mode, push_len, push_data};
    end

    always_ff @(posedge CLK_25MHz) begin
        if (RESET) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && full && !pop) overflow_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_spi_display_receiver.sv
// tb_spi_display_receiver: drives SPI frames from a bit-level model and checks
// the received FIFO entries against a scoreboard queue.
module tb_spi_display_receiver;
    logic CLK_25MHz = 0, RESET = 1, SPI_CS = 1, SPI_RESET = 1, SPI_DC = 0, SPI_SDI = 0, SPI_SCK = 0, RX_ACK = 0;
    logic [15:0] RX_DATA;
    logic [3:0] RX_LEN;
    logic RX_MODE, RX_VALID, OVERFLOW, DISP_IN_RESET;

    spi_display_receiver dut (
        .CLK_25MHz(CLK_25MHz), .RESET(RESET), .SPI_CS(SPI_CS), .SPI_RESET(SPI_RESET),
        .SPI_DC(SPI_DC), .SPI_SDI(SPI_SDI), .SPI_SCK(SPI_SCK), .RX_DATA(RX_DATA),
        .RX_LEN(RX_LEN), .RX_MODE(RX_MODE), .RX_VALID(RX_VALID), .RX_ACK(RX_ACK),
        .OVERFLOW(OVERFLOW), .DISP_IN_RESET(DISP_IN_RESET)
    );

    always #20 CLK_25MHz = ~CLK_25MHz;

    typedef struct {logic [15:0] d; logic [3:0] l; logic m;} ent_t;
    ent_t sb[$];
    logic [15:0] m_sh = 0;
    int m_cnt = 0;
    logic m_dc = 0;
    logic exp_ovf = 0;
    int n_checks = 0, n_fail = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge CLK_25MHz);
        #1;
    endtask

    task automatic model_push(input logic [15:0] d, input int l, input logic m);
        ent_t e;
        e.d = d; e.l = 4'(l); e.m = m;
        if (sb.size() < 4) sb.push_back(e);
        else exp_ovf = 1;
    endtask

    task automatic cs_low();
        SPI_CS = 0;
        tick(3);
    endtask

    task automatic shift_bits(input logic [31:0] data, input int n, input logic dc);
        SPI_DC = dc;
        for (int i = n - 1; i >= 0; i--) begin
            SPI_SDI = data[i];
            tick(2);
            SPI_SCK = 1;
            if (m_cnt == 0) m_dc = dc;
            m_sh = {m_sh[14:0], data[i]};
            m_cnt++;
            if (m_cnt == 16) begin
                model_push(m_sh, 15, m_dc);
                m_sh = 0; m_cnt = 0;
            end
            tick(2);
            SPI_SCK = 0;
        end
    endtask

    task automatic cs_high();
        tick(2);
        SPI_CS = 1;
        if (m_cnt > 0) model_push(m_sh, m_cnt - 1, m_dc);
        m_sh = 0; m_cnt = 0;
        tick(5);
    endtask

    task automatic frame(input logic [31:0] data, input int n, input logic dc);
        cs_low();
        shift_bits(data, n, dc);
        cs_high();
    endtask

    task automatic drain(input string name);
        ent_t e;
        int t;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            t = 0;
            while (!RX_VALID && t < 20) begin tick(1); t++; end
            n_checks++;
            if (RX_VALID !== 1'b1) begin
                n_fail++; $display("FAIL %s valid timeout: got %b want 1", name, RX_VALID);
            end
            n_checks++;
            if (RX_DATA !== e.d) begin n_fail++; $display("FAIL %s data: got %h want %h", name, RX_DATA, e.d); end
            n_checks++;
            if (RX_LEN !== e.l) begin n_fail++; $display("FAIL %s len: got %0d want %0d", name, RX_LEN, e.l); end
            n_checks++;
            if (RX_MODE !== e.m) begin n_fail++; $display("FAIL %s mode: got %b want %b", name, RX_MODE, e.m); end
            RX_ACK = 1;
            tick(1);
            RX_ACK = 0;
        end
        tick(1);
        n_checks++;
        if (RX_VALID !== 1'b0) begin n_fail++; $display("FAIL %s empty: got valid %b want 0", name, RX_VALID); end
    endtask

    task automatic test_reset();
        RESET = 1;
        tick(3);
        RESET = 0;
        tick(1);
        n_checks++;
        if ({RX_DATA, RX_LEN, RX_MODE, RX_VALID, OVERFLOW, DISP_IN_RESET} !== 24'd0) begin
            n_fail++;
            $display("FAIL reset outputs: got data %h len %0d mode %b valid %b ovf %b dir %b want all 0",
                     RX_DATA, RX_LEN, RX_MODE, RX_VALID, OVERFLOW, DISP_IN_RESET);
        end
        tick(4);
    endtask

    task automatic test_partial();
        frame(32'h0000_00AE, 8, 0);
        drain("partial8");
    endtask

    task automatic test_word16();
        frame(32'h0000_F800, 16, 1);
        drain("word16");
    endtask

    task automatic test_back_to_back();
        frame(32'h1234_5678, 32, 1);
        n_checks++;
        if (sb.size() != 2) begin n_fail++; $display("FAIL b2b model entries: got %0d want 2", sb.size()); end
        drain("back_to_back");
    endtask

    task automatic test_overflow();
        for (int w = 1; w <= 4; w++) frame(32'(w), 16, 0);
        n_checks++;
        if (OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL ovf early: got %b want 0", OVERFLOW); end
        frame(32'd5, 16, 0);
        n_checks++;
        if (OVERFLOW !== exp_ovf) begin n_fail++; $display("FAIL ovf set: got %b want %b", OVERFLOW, exp_ovf); end
        drain("overflow");
        n_checks++;
        if (OVERFLOW !== 1'b1) begin n_fail++; $display("FAIL ovf sticky: got %b want 1", OVERFLOW); end
    endtask

    task automatic test_hold();
        cs_low();
        shift_bits(32'h15, 5, 1);
        SPI_RESET = 0;
        m_sh = 0; m_cnt = 0;
        tick(4);
        n_checks++;
        if (DISP_IN_RESET !== 1'b1) begin n_fail++; $display("FAIL hold dir: got %b want 1", DISP_IN_RESET); end
        SPI_CS = 1;
        tick(5);
        n_checks++;
        if (RX_VALID !== 1'b0) begin n_fail++; $display("FAIL hold no push: got valid %b want 0", RX_VALID); end
        SPI_RESET = 1;
        tick(4);
        n_checks++;
        if (DISP_IN_RESET !== 1'b0) begin n_fail++; $display("FAIL hold release: got %b want 0", DISP_IN_RESET); end
        frame(32'h3C, 8, 0);
        drain("after_hold");
    endtask

    task automatic test_reset_midframe();
        frame(32'hA5A5_0F0F, 32, 1);
        n_checks++;
        if (RX_VALID !== 1'b1) begin n_fail++; $display("FAIL rstmid occupied: got valid %b want 1", RX_VALID); end
        cs_low();
        shift_bits(32'h1B, 5, 0);
        RESET = 1;
        tick(1);
        RESET = 0;
        sb.delete();
        m_sh = 0; m_cnt = 0; exp_ovf = 0;
        n_checks++;
        if ({RX_DATA, RX_VALID, OVERFLOW} !== 18'd0) begin
            n_fail++;
            $display("FAIL rstmid clear: got data %h valid %b ovf %b want 0", RX_DATA, RX_VALID, OVERFLOW);
        end
        tick(5);
        SPI_CS = 1;
        tick(6);
        n_checks++;
        if (RX_VALID !== 1'b0) begin n_fail++; $display("FAIL rstmid no push: got valid %b want 0", RX_VALID); end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_partial();
        test_word16();
        test_back_to_back();
        test_overflow();
        test_hold();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
